// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared constants and helpers for the bram_responder slice
// Contents: clog2 constant function, collision policy codes, read latency bounds.
package bram_pkg;

    // Cross-port collision policy codes for the WRITE_FIRST parameter.
    localparam int POLICY_READ_FIRST  = 0;
    localparam int POLICY_WRITE_FIRST = 1;

    // Supported read latency range, in clock edges.
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_read_pipe.sv
// rtl/bram_read_pipe.sv - per-port read latency pipe with no-change output hold
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; clears valid bits and output
//   rd_valid_i   a read was issued at this edge
//   rd_data_i    word fetched for that read
//   rd_data_o    read data; updates only when a result leaves the pipe
module bram_read_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_valid_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic                  tail_valid;
    logic [DATA_WIDTH-1:0] tail_data;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] hold_d;

    // LATENCY-1 shift stages feed the final hold register, so the hold
    // register updates exactly LATENCY edges after the read edge.
    generate
        if (LATENCY > 1) begin : g_shift
            logic [LATENCY-2:0]    vld_q;
            logic [DATA_WIDTH-1:0] dat_q [LATENCY-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY - 1; i++) begin
                        dat_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= rd_valid_i;
                    dat_q[0] <= rd_data_i;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        dat_q[i] <= dat_q[i-1];
                    end
                end
            end

            assign tail_valid = vld_q[LATENCY-2];
            assign tail_data  = dat_q[LATENCY-2];
        end else begin : g_direct
            assign tail_valid = rd_valid_i;
            assign tail_data  = rd_data_i;
        end
    endgenerate

    always_comb begin
        hold_d = hold_q;
        if (tail_valid) begin
            hold_d = tail_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign rd_data_o = hold_q;

endmodule

// File: rtl/bram_responder.sv
// rtl/bram_responder.sv - behavioural dual-port block-RAM responder for the memory adapter
// Optional feature macro: BRAM_COLLISION_CHECK_EN (adds sticky collision output).
// Ports:
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset (array contents are kept)
//   ce0/we0/address0     port 0 enable, write enable, word address
//   dout0                port 0 write data
//   ce1/we1/address1     port 1 enable, write enable, word address
//   dout1                port 1 write data
//   din0/din1            read data, READ_LATENCY edges after the read edge
//   err_oob              sticky: an enabled access addressed >= DEPTH
//   collision            sticky: same-address access with a write (feature only)
module bram_responder
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1,
    parameter int WRITE_FIRST  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] dout0,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] din1,
    output logic                  err_oob
`ifdef BRAM_COLLISION_CHECK_EN
    ,
    output logic                  collision
`endif
);

    localparam int IDX_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    // Out-of-range latencies are clamped into the supported window.
    localparam int LAT   = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                           READ_LATENCY;
    // One extra bit so DEPTH is representable even when it equals 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic             inr0, inr1;
    logic [IDX_W-1:0] idx0, idx1;
    logic             wr0, wr1;
    logic             rd0, rd1;
    logic             same_addr;
    logic [DATA_WIDTH-1:0] rd_data0, rd_data1;
    logic             err_oob_q, err_oob_d;

    assign inr0 = {1'b0, address0} < DEPTH_W;
    assign inr1 = {1'b0, address1} < DEPTH_W;
    assign idx0 = address0[IDX_W-1:0];
    assign idx1 = address1[IDX_W-1:0];

    assign wr0 = ce0 & we0 & inr0;
    assign wr1 = ce1 & we1 & inr1;
    assign rd0 = ce0 & ~we0;
    assign rd1 = ce1 & ~we1;

    assign same_addr = (address0 == address1);

    // Fetch for each reader. Out-of-range reads return zero. Under the
    // write-first policy a same-edge write on the other port is forwarded;
    // otherwise the array's pre-edge contents are returned.
    always_comb begin
        rd_data0 = '0;
        if (inr0) begin
            rd_data0 = mem[idx0];
            if ((WRITE_FIRST != POLICY_READ_FIRST) && wr1 && same_addr) begin
                rd_data0 = dout1;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (inr1) begin
            rd_data1 = mem[idx1];
            if ((WRITE_FIRST != POLICY_READ_FIRST) && wr0 && same_addr) begin
                rd_data1 = dout0;
            end
        end
    end

    // Array has no reset. Port 1 is assigned last so it wins a same-address
    // dual write.
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem[idx0] <= dout0;
        end
        if (wr1) begin
            mem[idx1] <= dout1;
        end
    end

    always_comb begin
        err_oob_d = err_oob_q | (ce0 & ~inr0) | (ce1 & ~inr1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oob_q <= 1'b0;
        end else begin
            err_oob_q <= err_oob_d;
        end
    end

    assign err_oob = err_oob_q;

`ifdef BRAM_COLLISION_CHECK_EN
    logic coll_hit;
    logic collision_q, collision_d;

    assign coll_hit = ce0 & ce1 & same_addr & (we0 | we1);

    always_comb begin
        collision_d = collision_q | coll_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    assign collision = collision_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && coll_hit) begin
            $display("bram_responder warning: port collision at %0t, address %h", $time, address0);
        end
    end
`endif
`endif

    bram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_pipe0 (
        .clk        (clk),
        .rst_n      (rst),
        .rd_valid_i (rd0),
        .rd_data_i  (rd_data0),
        .rd_data_o  (din0)
    );

    bram_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (LAT)
    ) u_pipe1 (
        .clk        (clk),
        .rst_n      (rst),
        .rd_valid_i (rd1),
        .rd_data_i  (rd_data1),
        .rd_data_o  (din1)
    );

endmodule

// File: tb/tb_bram_responder.sv
// tb/tb_bram_responder.sv - scoreboard bench driving three bram_responder configurations in parallel
module tb_bram_responder;

    // Instance a: latency 1, read-first. b: latency 3, write-first. c: latency 2, read-first.
    localparam int NI = 3;
    localparam int LATS [NI] = '{1, 3, 2};
    localparam int WFS  [NI] = '{0, 1, 0};

    typedef struct {
        int          due;
        logic [31:0] data;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        ce0, we0, ce1, we1;
    logic [31:0] address0, address1, dout0, dout1;

    logic [31:0] din0_a, din1_a, din0_b, din1_b, din0_c, din1_c;
    logic        err_a, err_b, err_c;
`ifdef BRAM_COLLISION_CHECK_EN
    logic        coll_a, coll_b, coll_c;
`endif

    logic [31:0] din_w   [2*NI];
    logic [31:0] exp_din [2*NI];
    logic        err_w   [NI];
    ent_t        sbq     [2*NI][$];
    logic [31:0] mdl     [16];

    int edge_n = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    assign din_w[0] = din0_a;
    assign din_w[1] = din1_a;
    assign din_w[2] = din0_b;
    assign din_w[3] = din1_b;
    assign din_w[4] = din0_c;
    assign din_w[5] = din1_c;
    assign err_w[0] = err_a;
    assign err_w[1] = err_b;
    assign err_w[2] = err_c;

    bram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(1), .WRITE_FIRST(0)) dut_a (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1),
        .din0(din0_a), .din1(din1_a), .err_oob(err_a)
`ifdef BRAM_COLLISION_CHECK_EN
        , .collision(coll_a)
`endif
    );

    bram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(3), .WRITE_FIRST(1)) dut_b (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1),
        .din0(din0_b), .din1(din1_b), .err_oob(err_b)
`ifdef BRAM_COLLISION_CHECK_EN
        , .collision(coll_b)
`endif
    );

    bram_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(16), .READ_LATENCY(2), .WRITE_FIRST(0)) dut_c (
        .clk(clk), .rst(rst),
        .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0),
        .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1),
        .din0(din0_c), .din1(din1_c), .err_oob(err_c)
`ifdef BRAM_COLLISION_CHECK_EN
        , .collision(coll_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: retire due scoreboard entries and compare every read port each cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2*NI; k++) begin
            if (!rst) begin
                sbq[k].delete();
                exp_din[k] = 32'h0;
            end else begin
                while (sbq[k].size() > 0 && sbq[k][0].due <= edge_n) begin
                    exp_din[k] = sbq[k][0].data;
                    void'(sbq[k].pop_front());
                end
            end
            n_cmp++;
            if (din_w[k] !== exp_din[k]) begin
                n_bad++;
                $display("FAIL din inst%0d port%0d edge %0d: got %h expected %h",
                         k/2, k%2, edge_n, din_w[k], exp_din[k]);
            end
        end
    end

    function automatic logic [31:0] mdl_read(input int wf, input logic [31:0] a,
                                             input logic other_wr, input logic [31:0] oa,
                                             input logic [31:0] od);
        logic [3:0] ix;
        if (a >= 32'd16) return 32'h0;
        if (wf != 0 && other_wr && oa == a) return od;
        ix = a[3:0];
        return mdl[ix];
    endfunction

    // Drive one edge's worth of requests, push expected read results, update the model.
    task automatic step(input logic c0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic c1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        logic ow0, ow1;
        logic [3:0] ix;
        ent_t e;
        ce0 = c0; we0 = w0; address0 = a0; dout0 = d0;
        ce1 = c1; we1 = w1; address1 = a1; dout1 = d1;
        ow0 = c0 && w0 && (a0 < 32'd16);
        ow1 = c1 && w1 && (a1 < 32'd16);
        for (int i = 0; i < NI; i++) begin
            if (c0 && !w0) begin
                e.due  = edge_n + LATS[i];
                e.data = mdl_read(WFS[i], a0, ow1, a1, d1);
                sbq[2*i].push_back(e);
            end
            if (c1 && !w1) begin
                e.due  = edge_n + LATS[i];
                e.data = mdl_read(WFS[i], a1, ow0, a0, d0);
                sbq[2*i+1].push_back(e);
            end
        end
        if (ow0) begin ix = a0[3:0]; mdl[ix] = d0; end
        if (ow1) begin ix = a1[3:0]; mdl[ix] = d1; end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) begin @(negedge clk); #1; end
        for (int k = 0; k < 2*NI; k++) begin
            n_cmp++;
            if (din_w[k] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_din%0d: got %h expected 0", k, din_w[k]);
            end
        end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (err_w[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_err_oob inst%0d: got %b expected 0", i, err_w[i]);
            end
        end
`ifdef BRAM_COLLISION_CHECK_EN
        n_cmp++;
        if ({coll_a, coll_b, coll_c} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_collision: got %b expected 000", {coll_a, coll_b, coll_c});
        end
`endif
        rst = 1'b1;
        idle(1);
    endtask

    task automatic test_write_read;
        step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 5, 0);
        n_cmp++;
        if (din1_a !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_read_lat1: got %h expected deadbeef", din1_a);
        end
        idle(4);
    endtask

    task automatic test_pipeline;
        for (int i = 0; i < 4; i++) step(1, 1, i, 10 + i, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, i, 0);
        idle(5);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (din_w[2*i+1] !== 32'd13) begin
                n_bad++;
                $display("FAIL pipeline_hold inst%0d: got %h expected 0000000d", i, din_w[2*i+1]);
            end
        end
    endtask

    task automatic test_collision;
        logic [31:0] want;
        step(1, 1, 7, 32'h1, 0, 0, 0, 0);
        step(1, 1, 7, 32'h2, 1, 0, 7, 0);
        idle(4);
        for (int i = 0; i < NI; i++) begin
            want = (WFS[i] != 0) ? 32'h2 : 32'h1;
            n_cmp++;
            if (din_w[2*i+1] !== want) begin
                n_bad++;
                $display("FAIL collision_policy inst%0d: got %h expected %h", i, din_w[2*i+1], want);
            end
        end
`ifdef BRAM_COLLISION_CHECK_EN
        n_cmp++;
        if ({coll_a, coll_b, coll_c} !== 3'b111) begin
            n_bad++;
            $display("FAIL collision_flag: got %b expected 111", {coll_a, coll_b, coll_c});
        end
`endif
    endtask

    task automatic test_dual_write;
        step(1, 1, 9, 32'hAA, 1, 1, 9, 32'hBB);
        step(1, 0, 9, 0, 0, 0, 0, 0);
        idle(4);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (din_w[2*i] !== 32'hBB) begin
                n_bad++;
                $display("FAIL dual_write inst%0d: got %h expected 000000bb", i, din_w[2*i]);
            end
        end
    endtask

    task automatic test_oob;
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (err_w[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL oob_pre inst%0d: got %b expected 0", i, err_w[i]);
            end
        end
        step(1, 1, 16, 32'h55, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 16, 0);
        step(0, 0, 0, 0, 1, 0, 32'h8000_0005, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (err_w[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL oob_flag inst%0d: got %b expected 1", i, err_w[i]);
            end
            n_cmp++;
            if (din_w[2*i] !== 32'd10) begin
                n_bad++;
                $display("FAIL oob_mem0 inst%0d: got %h expected 0000000a", i, din_w[2*i]);
            end
            n_cmp++;
            if (din_w[2*i+1] !== 32'h0) begin
                n_bad++;
                $display("FAIL oob_read inst%0d: got %h expected 0", i, din_w[2*i+1]);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        step(0, 0, 0, 0, 1, 0, 5, 0);
        rst = 1'b0;
        repeat (2) begin @(negedge clk); #1; end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (err_w[i] !== 1'b0) begin
                n_bad++;
                $display("FAIL midreset_err inst%0d: got %b expected 0", i, err_w[i]);
            end
        end
        rst = 1'b1;
        idle(4);
        n_cmp++;
        if (din1_c !== 32'h0) begin
            n_bad++;
            $display("FAIL midreset_discard: got %h expected 0", din1_c);
        end
        step(0, 0, 0, 0, 1, 0, 5, 0);
        idle(4);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (din_w[2*i+1] !== 32'hDEADBEEF) begin
                n_bad++;
                $display("FAIL midreset_mem_kept inst%0d: got %h expected deadbeef", i, din_w[2*i+1]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        ce0 = 1'b0; we0 = 1'b0; address0 = '0; dout0 = '0;
        ce1 = 1'b0; we1 = 1'b0; address1 = '0; dout1 = '0;
        test_reset();
        test_write_read();
        test_pipeline();
        test_collision();
        test_dual_write();
        test_oob();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_responder.md
Name: bram_responder

Overview:
- Behavioural dual-port block-RAM responder.
- Sits on the BRAM side of the circuit-to-BRAM memory adapter and replies to its ce/we/address/dout requests with read data on din0/din1.
- Port names mirror the adapter's BRAM-side names, so the two wire together one-to-one.
- Used in simulation and synthesizable test harnesses. Provides configurable read latency, a collision policy and out-of-range detection.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 32, address bus width
DEPTH, 1024, number of words; valid addresses are 0..DEPTH-1
READ_LATENCY, 1, cycles from read request edge to din valid; legal range 1..4
WRITE_FIRST, 0, cross-port same-address collision policy: 1 = reader sees new data, 0 = reader sees old data

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
ce0  input  1  port 0 enable
we0  input  1  port 0 write enable (qualified by ce0)
address0  input  ADDR_WIDTH  port 0 word address
dout0  input  DATA_WIDTH  port 0 write data
ce1  input  1  port 1 enable
we1  input  1  port 1 write enable (qualified by ce1)
address1  input  ADDR_WIDTH  port 1 word address
dout1  input  DATA_WIDTH  port 1 write data
din0  output  DATA_WIDTH  port 0 read data
din1  output  DATA_WIDTH  port 1 read data
err_oob  output  1  sticky flag: some enabled access was out of range
collision  output  1  sticky flag; exists only with the optional feature

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is asynchronous, active-low (rst=0 resets).
  - During reset: din0=0, din1=0, err_oob=0, collision=0, all read-pipeline valid bits cleared.
  - Memory array is NOT reset; contents survive reset.
- Write, port p:
  - Condition: ce_p=1, we_p=1, address_p<DEPTH at a rising edge.
  - Effect: mem[address_p] <= dout_p.
- Read, port p:
  - Condition: ce_p=1, we_p=0 at edge E.
  - din_p shows the word exactly READ_LATENCY edges after E (latency 1 = standard BRAM output register).
  - Back-to-back reads on consecutive cycles are fully pipelined: one result per cycle.
- Hold:
  - din_p changes only when a read result leaves the pipe.
  - It holds its value through idle cycles and through writes on the same port (no-change mode).
- Out of range (address_p >= DEPTH with ce_p=1):
  - Write is dropped.
  - Read returns 0 at the normal latency.
  - err_oob is set and stays 1 until reset.
  - Array index uses the low clog2(DEPTH) bits only after the range check passes.
- Cross-port collision (same in-range address, same edge, one port writes, the other reads):
  - WRITE_FIRST=1: reader receives the new write data.
  - WRITE_FIRST=0: reader receives the prior contents.
- Both ports write the same address on the same edge: port 1 data wins (deterministic).
- Same-port read of an address written on the previous edge returns the new data.
- Reset mid-operation: in-flight reads are discarded; din stays 0 until the first read issued after reset release completes.
- Adapter usage: port 0 write-only, port 1 read-only. The block supports the general case (reads on port 0, writes on port 1).

Optional Feature:
BRAM_COLLISION_CHECK_EN
- Defined:
  - Adds the collision output.
  - collision is set at any edge where ce0=ce1=1, address0==address1, and at least one of we0/we1 is 1.
  - Sticky until reset; reset value 0.
  - Also emits a simulation $display warning with time and address.
- Undefined: collision port and its logic are absent; datapath behaviour is identical.

Decomposition:
- Shared include/package bram_pkg:
  - clog2 constant function
  - WRITE_FIRST/READ_FIRST policy constants
  - READ_LATENCY legality bounds
- Sub-module bram_read_pipe:
  - Per-port valid+data shift register of depth READ_LATENCY-1 with final hold register.
  - Instantiated twice.
- Top level holds the array, write/collision arbitration, range check and flags.

Test Plan:
- Reset, write, read: rst low 3 cycles, then write 0xDEADBEEF to addr 5 via port 0, then read addr 5 on port 1 → din1=0xDEADBEEF one edge after the read edge (READ_LATENCY=1); din0/din1=0 during reset.
- Latency and pipelining: READ_LATENCY=3, consecutive reads of addrs 0..3 preloaded with 10,11,12,13 → din1 = 10,11,12,13 on cycles 3..6 after the first read; din1 holds 13 afterwards.
- Collision policy: mem[7]=0x1, port 0 writes 0x2 to addr 7 while port 1 reads addr 7 → din1=0x1 with WRITE_FIRST=0, 0x2 with WRITE_FIRST=1; collision=1 when BRAM_COLLISION_CHECK_EN is defined.
- Dual write: both ports write addr 9 (port 0 0xAA, port 1 0xBB) → later read returns 0xBB.
- Out of range: DEPTH=16, write 0x55 to addr 16, read addr 16 → din=0, err_oob=1 and stays 1; mem[0] unchanged.
- Reset mid-read: READ_LATENCY=2, assert rst one cycle after a read of addr 5 → din1 stays 0 after release; mem[5] still readable with its old value.
